fifo_sync_ext: RTL



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 27 ++
 rtl/fifo_sync_ext.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync_ext family: count width helper,
// threshold legality check and the reset value of the read data.
package fifo_pkg;

    localparam int FIFO_RST_DOUT = 0;

    function automatic int fifo_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit fifo_thresh_legal(input int depth, input int af_thresh,
                                             input int ae_thresh);
        return (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

    // Occupancy type for the default 16-deep geometry (0..DEPTH needs one extra bit).
    typedef logic [fifo_count_width(4)-1:0] fifo_count_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first
// on an address collision), no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset; a reset would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_ext.sv
// Synchronous FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for a first-word-fall-through output stage.
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = fifo_count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

    if (!fifo_thresh_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("fifo_sync_ext: AF_THRESH or AE_THRESH outside legal range");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_dout_live;
    logic                  w_rd_acc, w_wr_acc, w_ram_rd, w_empty_next;
    logic [CW-1:0]         w_count_next;
    logic [DATA_WIDTH-1:0] w_ram_q;

    assign w_rd_acc     = rd_en & ~r_empty;
    assign w_wr_acc     = wr_en & (~r_full | w_rd_acc);
    assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

`ifdef FIFO_FWFT_EN
    // The RAM read register is the output stage; r_empty tracks whether it holds a word.
    logic [CW-1:0] w_mem_count;
    assign w_mem_count  = r_count - CW'(~r_empty);
    assign w_ram_rd     = (w_mem_count != '0) & (r_empty | w_rd_acc);
    assign w_empty_next = ~(w_ram_rd | (~r_empty & ~w_rd_acc));
    assign valid        = ~r_empty;
`else
    logic r_valid;
    assign w_ram_rd     = w_rd_acc;
    assign w_empty_next = (w_count_next == '0);
    assign valid        = r_valid;

    always_ff @(posedge clk) begin
        if (reset) r_valid <= 1'b0;
        else       r_valid <= w_rd_acc;
    end
`endif

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_wr_acc),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(din),
        .i_rd_en  (w_ram_rd),
        .i_rd_addr(r_rd_ptr),
        .o_rd_data(w_ram_q)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_af        <= 1'b0;
            r_ae        <= 1'b1;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_dout_live <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_ram_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_count     <= w_count_next;
            r_full      <= (w_count_next == C_DEPTH);
            r_empty     <= w_empty_next;
            r_af        <= (w_count_next >= C_AF);
            r_ae        <= (w_count_next <= C_AE);
            r_ovf       <= (wr_en & ~w_wr_acc) | (r_ovf & ~err_clr);
            r_udf       <= (rd_en & ~w_rd_acc) | (r_udf & ~err_clr);
            r_dout_live <= r_dout_live | w_ram_rd;
        end
    end

    // RAM output is unreset, so dout shows the reset constant until the first read.
    assign dout         = r_dout_live ? w_ram_q : DATA_WIDTH'(FIFO_RST_DOUT);
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
